// File: rtl/gpr_multiport_rf_pkg.sv
// Shared definitions for the DLX general-purpose register file:
// sequencer state encoding and fixed register addresses.
package gpr_multiport_rf_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

    localparam int R0_ADR          = 0;
    localparam int FIX_ADR_DEFAULT = 10;

endpackage

// File: rtl/gpr_multiport_rf_bank.sv
// One storage bank: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// The register file keeps one replica per read port, all written identically.
module rf_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/gpr_multiport_rf.sv
// DLX general-purpose register file: NUM_RD async read ports, one fixed-address port E,
// one write port, R0 hard-wired to zero, optional write-to-read bypass and a clear sequencer.
module gpr_multiport_rf
    import gpr_multiport_rf_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 3,
    parameter int FIX_ADR = FIX_ADR_DEFAULT,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     ready,
    input  logic                     GPR_WE,
    input  logic [ADDR_W-1:0]        C_ADR,
    input  logic [DATA_W-1:0]        C,
    input  logic [NUM_RD*ADDR_W-1:0] RD_ADR,
    output logic [NUM_RD*DATA_W-1:0] RD_DATA,
    output logic [DATA_W-1:0]        E,
    output logic                     AEQZ
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADR = ADDR_W'(R0_ADR);
    localparam logic [ADDR_W-1:0] E_ADR    = ADDR_W'(FIX_ADR);
    localparam logic [ADDR_W-1:0] ONE_ADR  = ADDR_W'(1);

    rf_state_e         state_r;
    rf_state_e         state_next;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W-1:0] clr_cnt_next;

    logic              user_we;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata [NUM_RD];
    logic [DATA_W-1:0] e_rdata;
    logic              e_hit;

    // Zero while clearing or for R0; otherwise the bypassed or stored value.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              rdy,
        input logic [ADDR_W-1:0] adr,
        input logic              hit,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] res;
        if (!rdy || (adr == ZERO_ADR)) begin
            res = {DATA_W{1'b0}};
        end else if (hit) begin
            res = wr_data;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= ONE_ADR;
        end else begin
            state_r   <= state_next;
            clr_cnt_r <= clr_cnt_next;
        end
    end

    // Sequencer next state; clr_cnt stops at the last entry so it never wraps
    always_comb begin
        state_next   = state_r;
        clr_cnt_next = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_ADR) begin
                    state_next = ST_READY;
                end else begin
                    clr_cnt_next = clr_cnt_r + ONE_ADR;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = ONE_ADR;
                end else begin
                    state_next = ST_READY;
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_cnt_next = ONE_ADR;
            end
        endcase
    end

    assign ready   = (state_r == ST_READY);
    assign user_we = GPR_WE && ready && (C_ADR != ZERO_ADR);

    // Shared write source: clear sequencer or the user port
    always_comb begin
        if (state_r == ST_CLEAR) begin
            bank_we    = !reset;
            bank_waddr = clr_cnt_r;
            bank_wdata = {DATA_W{1'b0}};
        end else begin
            bank_we    = user_we && !reset;
            bank_waddr = C_ADR;
            bank_wdata = C;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] adr;
        logic              hit;

        assign adr = RD_ADR[i*ADDR_W +: ADDR_W];
        assign hit = (BYPASS != 0) && user_we && (C_ADR == adr);

        rf_bank #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we),
            .waddr(bank_waddr),
            .wdata(bank_wdata),
            .raddr(adr),
            .rdata(bank_rdata[i])
        );

        assign RD_DATA[i*DATA_W +: DATA_W] = read_mux(ready, adr, hit, C, bank_rdata[i]);
    end

    rf_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_bank_e (
        .clk  (clk),
        .we   (bank_we),
        .waddr(bank_waddr),
        .wdata(bank_wdata),
        .raddr(E_ADR),
        .rdata(e_rdata)
    );

    assign e_hit = (BYPASS != 0) && user_we && (C_ADR == E_ADR);
    assign E     = read_mux(ready, E_ADR, e_hit, C, e_rdata);
    assign AEQZ  = ~|RD_DATA[DATA_W-1:0];

endmodule

// File: tb/tb_gpr_multiport_rf.sv
// Directed bench for gpr_multiport_rf: one instance with bypass, one without,
// driven by the same stimulus.
module tb_gpr_multiport_rf;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        gpr_we;
    logic [4:0]  c_adr;
    logic [31:0] c_data;
    logic [14:0] rd_adr;

    logic        ready_b,   ready_n;
    logic [95:0] rd_data_b, rd_data_n;
    logic [31:0] e_b,       e_n;
    logic        aeqz_b,    aeqz_n;

    int total  = 0;
    int passed = 0;
    int n;

    always #5 clk = ~clk;

    gpr_multiport_rf #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
        .GPR_WE(gpr_we), .C_ADR(c_adr), .C(c_data), .RD_ADR(rd_adr),
        .RD_DATA(rd_data_b), .E(e_b), .AEQZ(aeqz_b)
    );

    gpr_multiport_rf #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_n),
        .GPR_WE(gpr_we), .C_ADR(c_adr), .C(c_data), .RD_ADR(rd_adr),
        .RD_DATA(rd_data_n), .E(e_n), .AEQZ(aeqz_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready_b !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0; gpr_we = 1'b0;
        c_adr = 5'd0; c_data = 32'd0; rd_adr = 15'd0;

        // 1: one-cycle reset, then 31-cycle clear, then all entries zero
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready_b}, 32'd0);
        chk("rst_rd0", rd_data_b[31:0], 32'd0);
        chk("rst_rd2", rd_data_b[95:64], 32'd0);
        chk("rst_e", e_b, 32'd0);
        chk("rst_aeqz", {31'd0, aeqz_b}, 32'd1);
        reset = 1'b0;
        wait_ready(n);
        chk("clr_len", n, 32'd31);
        chk("clr_ready_nb", {31'd0, ready_n}, 32'd1);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_adr = {5'(a), 5'(a), 5'(a)};
            #1;
            chk("clr_rd0", rd_data_b[31:0], 32'd0);
            chk("clr_rd2", rd_data_n[95:64], 32'd0);
        end
        chk("clr_e", e_b, 32'd0);

        // 2: write R5, read on ports 0 and 2
        @(negedge clk);
        rd_adr = 15'd0;
        gpr_we = 1'b1; c_adr = 5'd5; c_data = 32'hDEADBEEF;
        @(negedge clk);
        gpr_we = 1'b0;
        rd_adr = {5'd5, 5'd0, 5'd5};
        #1;
        chk("r5_p0", rd_data_b[31:0], 32'hDEADBEEF);
        chk("r5_p2", rd_data_b[95:64], 32'hDEADBEEF);
        chk("r5_p1_r0", rd_data_b[63:32], 32'd0);
        chk("r5_aeqz", {31'd0, aeqz_b}, 32'd0);
        chk("r5_p0_nb", rd_data_n[31:0], 32'hDEADBEEF);

        // 3: writes to R0 are discarded and never bypassed
        @(negedge clk);
        gpr_we = 1'b1; c_adr = 5'd0; c_data = 32'h12345678;
        rd_adr = 15'd0;
        #1;
        chk("r0_byp", rd_data_b[31:0], 32'd0);
        chk("r0_byp_aeqz", {31'd0, aeqz_b}, 32'd1);
        @(negedge clk);
        gpr_we = 1'b0;
        #1;
        chk("r0_after", rd_data_b[31:0], 32'd0);
        chk("r0_aeqz_nb", {31'd0, aeqz_n}, 32'd1);

        // 4: same-cycle write of R10 while port1 reads R10
        @(negedge clk);
        gpr_we = 1'b1; c_adr = 5'd10; c_data = 32'hA5A5A5A5;
        rd_adr = {5'd0, 5'd10, 5'd0};
        #1;
        chk("byp_p1", rd_data_b[63:32], 32'hA5A5A5A5);
        chk("byp_e", e_b, 32'hA5A5A5A5);
        chk("nobyp_p1", rd_data_n[63:32], 32'd0);
        chk("nobyp_e", e_n, 32'd0);
        @(negedge clk);
        gpr_we = 1'b0;
        #1;
        chk("nobyp_p1_next", rd_data_n[63:32], 32'hA5A5A5A5);
        chk("nobyp_e_next", e_n, 32'hA5A5A5A5);
        chk("byp_e_next", e_b, 32'hA5A5A5A5);

        // 5: clear request with a simultaneous write of R7; write of R3 during clear dropped
        @(negedge clk);
        gpr_we = 1'b1; c_adr = 5'd7; c_data = 32'h00000055;
        clear_req = 1'b1;
        rd_adr = {5'd0, 5'd0, 5'd7};
        #1;
        chk("creq_ready", {31'd0, ready_b}, 32'd1);
        @(negedge clk);
        clear_req = 1'b0;
        c_adr = 5'd3; c_data = 32'h00000077;
        rd_adr = {5'd0, 5'd0, 5'd3};
        #1;
        chk("cl_ready", {31'd0, ready_b}, 32'd0);
        chk("cl_rd0", rd_data_b[31:0], 32'd0);
        chk("cl_e", e_b, 32'd0);
        chk("cl_aeqz", {31'd0, aeqz_b}, 32'd1);
        @(negedge clk);
        gpr_we = 1'b0;
        wait_ready(n);
        chk("cl_done", {31'd0, ready_b}, 32'd1);
        @(negedge clk);
        rd_adr = {5'd5, 5'd3, 5'd7};
        #1;
        chk("cl_r7", rd_data_b[31:0], 32'd0);
        chk("cl_r3", rd_data_b[63:32], 32'd0);
        chk("cl_r5", rd_data_n[95:64], 32'd0);
        chk("cl_r10", e_b, 32'd0);

        // 6: reset at clr_cnt=12 restarts the sequence
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_ready", {31'd0, ready_b}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready(n);
        chk("restart_len", n, 32'd31);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
